// File: rtl/aes_stream_pkg.sv
// Shared widths, stream type codes and the FSM state encoding for the AES stream
// adapters.
package aes_stream_pkg;

  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = 4;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_KEY  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } st_e;

  // Per-cycle control decoded from the FSM state and the incoming word.
  typedef struct packed {
    logic ld;     // word starts a new block
    logic shift;  // word continues the current block
    logic done;   // word completes the block
    logic mis;    // type mismatch, partial block dropped
    logic to;     // gap timeout, partial block dropped
  } ctl_t;

endpackage

// File: rtl/stream_in_gap_timer.sv
// Idle-cycle counter between words of one block. A single-cycle expire pulse
// fires on the idle cycle that makes the count reach TIMEOUT; TIMEOUT=0 disables it.
module stream_in_gap_timer #(
  parameter int TIMEOUT = 8,
  parameter int TW      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [TW-1:0] LAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  localparam logic          EN   = (TIMEOUT != 0);

  logic [TW-1:0] gcnt;

  assign expire = EN && inc && (gcnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               gcnt <= '0;
    else if (clr || expire) gcnt <= '0;
    else if (inc && EN)     gcnt <= gcnt + 1'b1;
  end

endmodule

// File: rtl/stream_in.sv
// Reassembles four 32-bit stream words into one 128-bit AES block with framing
// checks. Define STREAM_IN_STATS_EN to add the blk_cnt/err_cnt statistics outputs.
module stream_in
  import aes_stream_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int TW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vin,
  input  logic              tin,
  input  logic [WORD_W-1:0] din,
  output logic              vout,
  output logic              tout,
  output logic [BLK_W-1:0]  dout,
  output logic              err
`ifdef STREAM_IN_STATS_EN
  ,
  output logic [15:0]       blk_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int            SW   = BLK_W - WORD_W;
  localparam logic [1:0]    LAST = 2'(WORDS_PER_BLK - 1);

  st_e           state, nstate;
  ctl_t          ctl;
  logic [1:0]    wcnt;
  logic          ctype;
  logic [SW-1:0] sreg;   // earlier words of the block; the last one comes straight from din
  logic          expire;

  stream_in_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state == ST_IDLE) || vin),
    .inc    ((state == ST_FILL) && !vin),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      ST_IDLE: if (vin) nstate = ST_FILL;
      ST_FILL: if (ctl.done || ctl.to) nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  // A mismatched word restarts the block rather than being dropped.
  always_comb begin
    ctl = '0;
    case (state)
      ST_IDLE: ctl.ld = vin;
      ST_FILL: begin
        if (vin) begin
          if (tin == ctype) begin
            ctl.shift = 1'b1;
            ctl.done  = (wcnt == LAST);
          end else begin
            ctl.mis = 1'b1;
            ctl.ld  = 1'b1;
          end
        end else begin
          ctl.to = expire;
        end
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vout  <= 1'b0;
      err   <= 1'b0;
      tout  <= TYPE_DATA;
      dout  <= '0;
      sreg  <= '0;
      wcnt  <= '0;
      ctype <= TYPE_DATA;
    end else begin
      vout <= ctl.done;
      err  <= ctl.mis | ctl.to;
      if (ctl.ld) begin
        sreg  <= {{(SW-WORD_W){1'b0}}, din};
        wcnt  <= 2'd1;
        ctype <= tin;
      end else if (ctl.shift) begin
        sreg <= {sreg[SW-WORD_W-1:0], din};
        wcnt <= ctl.done ? 2'd0 : wcnt + 2'd1;
      end else if (ctl.to) begin
        wcnt <= 2'd0;
      end
      if (ctl.done) begin
        dout <= {sreg, din};
        tout <= ctype;
      end
    end
  end

`ifdef STREAM_IN_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (vout)                   blk_cnt <= blk_cnt + 16'd1;
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_in.sv
// Directed table-driven bench for stream_in: framing, gaps, mismatches, reset.
module tb_stream_in;
  import aes_stream_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         vin = 1'b0;
  logic         tin = 1'b0;
  logic [31:0]  din = '0;
  logic         vout, tout, err;
  logic [127:0] dout;
`ifdef STREAM_IN_STATS_EN
  logic [15:0]  blk_cnt;
  logic [7:0]   err_cnt;
`endif

  stream_in #(.TIMEOUT(8), .TW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .vin     (vin),
    .tin     (tin),
    .din     (din),
    .vout    (vout),
    .tout    (tout),
    .dout    (dout),
    .err     (err)
`ifdef STREAM_IN_STATS_EN
    ,
    .blk_cnt (blk_cnt),
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs driven in a cycle, and the outputs expected to be visible during it
  // (the registered result of the previous cycle's inputs).
  typedef struct {
    logic         vin;
    logic         tin;
    logic [31:0]  din;
    logic         ev;
    logic         ee;
    logic [127:0] ed;
    logic         et;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nbad = 0;

  function automatic logic [31:0] w(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction

  function automatic void add(input logic v, input logic t, input logic [31:0] d,
                              input logic ev, input logic ee,
                              input logic [127:0] ed, input logic et);
    vec_t r;
    r.vin = v; r.tin = t; r.din = d;
    r.ev = ev; r.ee = ee; r.ed = ed; r.et = et;
    tbl.push_back(r);
  endfunction

  task automatic check(input string nm, input logic ev, input logic ee,
                       input logic [127:0] ed, input logic et);
    nvec++;
    if (vout !== ev || err !== ee || dout !== ed || tout !== et) begin
      nbad++;
      $display("FAIL %s: got vout=%b err=%b tout=%b dout=%h, want vout=%b err=%b tout=%b dout=%h",
               nm, vout, err, tout, dout, ev, ee, et, ed);
    end
  endtask

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  initial begin
    logic [127:0] z, a, k, d, g, j, n, p, q;
    logic [31:0]  h0, h1, m0, m1;
    z  = '0;
    a  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    k  = 128'h11111111_22222222_33333333_44444444;
    d  = 128'h55555555_66666666_77777777_88888888;
    g  = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
    j  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    n  = 128'h0A0B0C0D_1A1B1C1D_2A2B2C2D_3A3B3C3D;
    p  = 128'hBAD0BAD0_BAD1BAD1_00000000_00000000;
    q  = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
    h0 = 32'h99999999; h1 = 32'h98989898;
    m0 = 32'hDEADBEEF; m1 = 32'hCAFEBABE;

    // single data block
    add(0, 0, 0, 0, 0, z, 0);
    for (int i = 0; i < 4; i++) add(1, TYPE_DATA, w(a, i), 0, 0, z, 0);
    add(0, 0, 0, 1, 0, a, 0);
    add(0, 0, 0, 0, 0, a, 0);
    // back-to-back key then data, second block starts on the vout cycle
    for (int i = 0; i < 4; i++) add(1, TYPE_KEY, w(k, i), 0, 0, a, 0);
    add(1, TYPE_DATA, w(d, 0), 1, 0, k, 1);
    for (int i = 1; i < 4; i++) add(1, TYPE_DATA, w(d, i), 0, 0, k, 1);
    add(0, 0, 0, 1, 0, d, 0);
    // 3-cycle gap after word 2 is tolerated
    add(1, TYPE_KEY, w(g, 0), 0, 0, d, 0);
    add(1, TYPE_KEY, w(g, 1), 0, 0, d, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, d, 0);
    add(1, TYPE_KEY, w(g, 2), 0, 0, d, 0);
    add(1, TYPE_KEY, w(g, 3), 0, 0, d, 0);
    add(0, 0, 0, 1, 0, g, 1);
    // 9-cycle gap: err after the 8th idle cycle, outputs hold
    add(1, TYPE_DATA, h0, 0, 0, g, 1);
    add(1, TYPE_DATA, h1, 0, 0, g, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, g, 1);
    add(0, 0, 0, 0, 1, g, 1);
    for (int i = 0; i < 4; i++) add(1, TYPE_DATA, w(j, i), 0, 0, g, 1);
    add(0, 0, 0, 1, 0, j, 0);
    // type mismatch on word 3 restarts the block with that word
    add(1, TYPE_DATA, m0, 0, 0, j, 0);
    add(1, TYPE_DATA, m1, 0, 0, j, 0);
    add(1, TYPE_KEY, w(n, 0), 0, 0, j, 0);
    add(1, TYPE_KEY, w(n, 1), 0, 1, j, 0);
    add(1, TYPE_KEY, w(n, 2), 0, 0, j, 0);
    add(1, TYPE_KEY, w(n, 3), 0, 0, j, 0);
    add(0, 0, 0, 1, 0, n, 1);
    add(0, 0, 0, 0, 0, n, 1);

    #3;
    check("reset", 0, 0, z, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("row%0d", i), tbl[i].ev, tbl[i].ee, tbl[i].ed, tbl[i].et);
      vin = tbl[i].vin; tin = tbl[i].tin; din = tbl[i].din;
    end

`ifdef STREAM_IN_STATS_EN
    @(negedge clk);
    check_val("blk_cnt", 32'(blk_cnt), 32'd6);
    check_val("err_cnt", 32'(err_cnt), 32'd2);
`endif

    // asynchronous reset mid-block, between clock edges
    @(negedge clk); vin = 1'b1; tin = TYPE_KEY; din = w(p, 0);
    @(negedge clk); din = w(p, 1);
    @(negedge clk); vin = 1'b0; din = '0;
    #2 rst = 1'b0;
    #1 check("async_rst", 0, 0, z, 0);
`ifdef STREAM_IN_STATS_EN
    check_val("rst_blk_cnt", 32'(blk_cnt), 32'd0);
`endif
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d", i), 0, 0, z, 0);
      vin = 1'b1; tin = TYPE_DATA; din = w(q, i);
    end
    @(negedge clk);
    check("post_rst_blk", 1, 0, q, 0);
    vin = 1'b0; din = '0;
    @(negedge clk);
    check("post_rst_hold", 0, 0, q, 0);

`ifdef STREAM_IN_STATS_EN
    // alternating types: every word after the first is a mismatch
    for (int i = 0; i < 302; i++) begin
      @(negedge clk);
      vin = 1'b1; tin = i[0]; din = 32'(i);
    end
    @(negedge clk); vin = 1'b0;
    repeat (3) @(negedge clk);
    check_val("err_cnt_sat", 32'(err_cnt), 32'hFF);
    check_val("blk_cnt_keep", 32'(blk_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/stream_in.md
Name: stream_in

Overview:
- Receive-side counterpart of the 128-bit-to-32-bit output serializer in the AES datapath.
- Collects four consecutive 32-bit words plus a type flag (key/data) from an external 32-bit stream.
- Assembles them into one 128-bit block and presents it to the AES core as a single-cycle valid pulse.
- Checks framing: type consistency within a block, and inter-word gap timeout.

Parameters:
- TIMEOUT, 8, max idle cycles allowed between words of one block; 0 disables the timeout.
- TW, 4, width of the gap counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- vin  input  1  input word valid.
- tin  input  1  input word type (0 = data, 1 = key), qualified by vin.
- din  input  32  input word, qualified by vin.
- vout  output  1  assembled block valid; one-cycle pulse.
- tout  output  1  block type; holds until the next vout.
- dout  output  128  assembled block; holds until the next vout.
- err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-low. While rst=0, all outputs and state are cleared asynchronously: vout=0, tout=0, dout=0, err=0, state=IDLE, word count=0, gap counter=0.
- Word order: big-endian. First word goes to dout[127:96], second to [95:64], third to [63:32], fourth to [31:0].
- Block framing:
  - Internal 2-bit word count wcnt.
  - Shift register sreg[127:0]; words shift in at the LSB end.
  - Block type captured from tin on the first word.
- FSM, two states:
  - IDLE: vin=1 → capture din and tin, wcnt=1, go to FILL. vin=0 → stay.
  - FILL, vin=1, tin equals captured type:
    - Shift in din, wcnt+1.
    - On the 4th word, the next cycle has dout = {w0,w1,w2,w3}, tout = captured type, vout=1; go to IDLE, wcnt=0.
  - FILL, vin=1, tin differs:
    - err=1 next cycle; partial block discarded.
    - The current word is the first word of a new block (wcnt=1, new type); stay in FILL.
  - FILL, vin=0: gap counter increments.
    - TIMEOUT≠0 and the counter reaches TIMEOUT → err=1 next cycle, partial block discarded, go to IDLE.
    - Gap counter clears on every accepted word.
- Latency: vout rises exactly 1 cycle after the clock edge that samples the 4th word.
- Back-to-back blocks:
  - A word arriving in the cycle where vout=1 is accepted as the first word of the next block. No bubble is required.
  - Sustained throughput is 1 block per 4 cycles.
- Output hold: dout and tout update only on completion; they are unaffected by errors.
- Simultaneous events: a type mismatch on the cycle the gap counter would expire resolves as the mismatch rule. Only one err pulse is produced.
- vout and err never assert in the same cycle.
- Reset mid-block: the partial block is lost; no vout or err is produced.
- Compatibility: a single tin value over 4 consecutive vin cycles, as produced by the output serializer, always reassembles losslessly.

Optional Feature:
- Macro: STREAM_IN_STATS_EN.
- Defined: adds outputs blk_cnt[15:0] and err_cnt[7:0].
  - blk_cnt increments on each vout and wraps at 16'hFFFF→0.
  - err_cnt increments on each err and saturates at 8'hFF.
  - Both cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package aes_stream_pkg:
  - WORD_W=32, BLK_W=128, WORDS_PER_BLK=4.
  - TYPE_DATA=1'b0, TYPE_KEY=1'b1.
  - Shared state encoding ST_IDLE / ST_FILL.
- One sub-module, stream_in_gap_timer:
  - Gap counter with clear, increment and TIMEOUT compare.
  - Expiry pulse output; disabled when TIMEOUT=0.

Test Plan:
- Single block: vin=1 for 4 cycles, tin=0, din=32'h00112233, 44556677, 8899AABB, CCDDEEFF → one cycle later vout=1, dout=128'h00112233445566778899AABBCCDDEEFF, tout=0, err=0.
- Back-to-back: 8 consecutive words, key block (tin=1) then data block (tin=0) → vout pulses at cycles 5 and 9 with the correct dout; tout is 1 then 0.
- Gap tolerance: TIMEOUT=8, 3-cycle gap after word 2 → block completes normally. With a 9-cycle gap → err pulse, no vout; the next 4 words form a valid block.
- Type mismatch: words 1–2 with tin=0, word 3 with tin=1 → err=1 next cycle. Word 3 plus three more tin=1 words → vout, tout=1, with word 3 in dout[127:96].
- Reset mid-block: 2 words, then rst=0 asynchronously → all outputs 0 immediately. After release, 4 words → correct block; the earlier words are absent.
- STATS (macro defined): 3 good blocks and 2 errors → blk_cnt=3, err_cnt=2. Force 300 errors → err_cnt=8'hFF.
